// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares main memory port B between the display
// processor (A) and the host/DMA loader (B) with bounded round-robin.
module mem_port_arbiter #(
  parameter int MAIN_MEMORY_BYTES = 2048,
  parameter int MAX_BURST         = 4,
  parameter int AW                = $clog2(MAIN_MEMORY_BYTES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_req,
  input  logic [AW-1:0] a_addr,
  input  logic [31:0]   a_wr_data,
  input  logic [3:0]    a_wr_en,
  output logic          a_gnt,
  output logic [31:0]   a_rd_data,
  output logic          a_rd_valid,
  input  logic          b_req,
  input  logic [AW-1:0] b_addr,
  input  logic [31:0]   b_wr_data,
  input  logic [3:0]    b_wr_en,
  output logic          b_gnt,
  output logic [31:0]   b_rd_data,
  output logic          b_rd_valid,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wr_data,
  output logic [3:0]    mem_wr_en,
  output logic          mem_rd_en,
  input  logic [31:0]   mem_rd_data
);

  localparam int CW = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MAXC = CW'(MAX_BURST);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_b_q, last_b_d;
  logic          a_vld_q, b_vld_q;
  logic          below_max;

  assign below_max = (cnt_q < MAXC);

  // Mealy grant decision; nothing is granted while reset is high
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (!reset) begin
      unique case (state_q)
        IDLE: begin
          if (a_req && b_req) begin
            a_gnt = last_b_q;
            b_gnt = !last_b_q;
          end else begin
            a_gnt = a_req;
            b_gnt = b_req;
          end
        end
        OWN_A: begin
          if (a_req && (below_max || !b_req))
            a_gnt = 1'b1;
          else
            b_gnt = b_req;
        end
        OWN_B: begin
          if (b_req && (below_max || !a_req))
            b_gnt = 1'b1;
          else
            a_gnt = a_req;
        end
        default: begin
          a_gnt = 1'b0;
          b_gnt = 1'b0;
        end
      endcase
    end
  end

  // Ownership, burst count and tie-break history for the next cycle
  always_comb begin
    state_d  = IDLE;
    cnt_d    = '0;
    last_b_d = last_b_q;
    if (a_gnt) begin
      last_b_d = 1'b0;
      state_d  = OWN_A;
      if (state_q == OWN_A)
        cnt_d = below_max ? cnt_q + ONE : cnt_q;
      else
        cnt_d = ONE;
    end else if (b_gnt) begin
      last_b_d = 1'b1;
      state_d  = OWN_B;
      if (state_q == OWN_B)
        cnt_d = below_max ? cnt_q + ONE : cnt_q;
      else
        cnt_d = ONE;
    end
  end

  // Route the granted requester onto the memory port
  always_comb begin
    mem_addr    = '0;
    mem_wr_data = '0;
    mem_wr_en   = '0;
    mem_rd_en   = 1'b0;
    if (a_gnt) begin
      mem_addr    = a_addr;
      mem_wr_data = a_wr_data;
      mem_wr_en   = a_wr_en;
      mem_rd_en   = (a_wr_en == 4'h0);
    end else if (b_gnt) begin
      mem_addr    = b_addr;
      mem_wr_data = b_wr_data;
      mem_wr_en   = b_wr_en;
      mem_rd_en   = (b_wr_en == 4'h0);
    end
  end

  // Arbiter state and read-return tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      last_b_q <= 1'b1;
      a_vld_q  <= 1'b0;
      b_vld_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_b_q <= last_b_d;
      a_vld_q  <= a_gnt && (a_wr_en == 4'h0);
      b_vld_q  <= b_gnt && (b_wr_en == 4'h0);
    end
  end

  // A read caught by reset still returns data but is never flagged valid
  assign a_rd_valid = a_vld_q && !reset;
  assign b_rd_valid = b_vld_q && !reset;
  assign a_rd_data  = mem_rd_data;
  assign b_rd_data  = mem_rd_data;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of grants, muxing and read return
// against a small byte-enabled memory model with 1-cycle read latency.
module tb_mem_port_arbiter;

  localparam int AW = 11;

  logic          clk = 1'b0;
  logic          reset;
  logic          a_req, b_req;
  logic [AW-1:0] a_addr, b_addr;
  logic [31:0]   a_wr_data, b_wr_data;
  logic [3:0]    a_wr_en, b_wr_en;
  logic          a_gnt, b_gnt;
  logic [31:0]   a_rd_data, b_rd_data;
  logic          a_rd_valid, b_rd_valid;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wr_data;
  logic [3:0]    mem_wr_en;
  logic          mem_rd_en;
  logic [31:0]   mem_rd_data;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [0:511];

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .MAIN_MEMORY_BYTES(2048),
    .MAX_BURST(4)
  ) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_addr(a_addr),
    .a_wr_data(a_wr_data), .a_wr_en(a_wr_en),
    .a_gnt(a_gnt), .a_rd_data(a_rd_data),
    .a_rd_valid(a_rd_valid),
    .b_req(b_req), .b_addr(b_addr),
    .b_wr_data(b_wr_data), .b_wr_en(b_wr_en),
    .b_gnt(b_gnt), .b_rd_data(b_rd_data),
    .b_rd_valid(b_rd_valid),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
    .mem_rd_data(mem_rd_data)
  );

  always @(posedge clk) begin
    if (mem_rd_en)
      mem_rd_data <= mem[mem_addr[10:2]];
    for (int i = 0; i < 4; i++)
      if (mem_wr_en[i])
        mem[mem_addr[10:2]][8*i +: 8] <= mem_wr_data[8*i +: 8];
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(negedge clk);
  endtask

  task automatic idle_in;
    a_req = 0; b_req = 0;
    a_wr_en = 0; b_wr_en = 0;
    a_wr_data = 0; b_wr_data = 0;
    a_addr = 0; b_addr = 0;
  endtask

  logic [9:0] exp_a;

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 32'h0;
    mem[4] = 32'h11111111;
    mem_rd_data = 0;
    idle_in();
    reset = 1;

    // reset holds grants and memory strobes low even with requests
    cyc(); a_req = 1; b_req = 1; #1;
    chk("rst_a_gnt", 32'(a_gnt), 0);
    chk("rst_b_gnt", 32'(b_gnt), 0);
    chk("rst_rd_en", 32'(mem_rd_en), 0);
    chk("rst_wr_en", 32'(mem_wr_en), 0);
    cyc(); idle_in(); reset = 0; #1;
    chk("rst_a_vld", 32'(a_rd_valid), 0);
    chk("rst_b_vld", 32'(b_rd_valid), 0);

    // A alone reads 0x010 three times
    for (int k = 0; k < 3; k++) begin
      cyc(); a_req = 1; a_addr = 11'h010; #1;
      chk($sformatf("rdA_gnt%0d", k), 32'(a_gnt), 1);
      chk($sformatf("rdA_bgnt%0d", k), 32'(b_gnt), 0);
      chk($sformatf("rdA_rden%0d", k), 32'(mem_rd_en), 1);
      chk($sformatf("rdA_addr%0d", k), 32'(mem_addr), 32'h010);
      chk($sformatf("rdA_vld%0d", k), 32'(a_rd_valid),
          (k == 0) ? 32'd0 : 32'd1);
      if (k > 0)
        chk($sformatf("rdA_data%0d", k), a_rd_data, 32'h11111111);
      chk($sformatf("rdA_bvld%0d", k), 32'(b_rd_valid), 0);
    end
    cyc(); idle_in(); #1;
    chk("rdA_vld3", 32'(a_rd_valid), 1);
    chk("rdA_data3", a_rd_data, 32'h11111111);
    chk("rdA_idle_rden", 32'(mem_rd_en), 0);
    chk("rdA_idle_addr", 32'(mem_addr), 0);
    cyc(); #1;
    chk("rdA_vld_end", 32'(a_rd_valid), 0);

    // fresh reset so A wins the first tie
    cyc(); reset = 1;
    cyc(); reset = 0;

    // continuous contention: A x4, B x4, A x2
    exp_a = 10'b1100001111;
    for (int k = 0; k < 10; k++) begin
      cyc(); a_req = 1; b_req = 1;
      a_addr = 11'h040; b_addr = 11'h080; #1;
      chk($sformatf("rr_a%0d", k), 32'(a_gnt), 32'(exp_a[k]));
      chk($sformatf("rr_b%0d", k), 32'(b_gnt), 32'(!exp_a[k]));
    end
    cyc(); idle_in(); #1;
    chk("rr_drop_a", 32'(a_gnt), 0);
    chk("rr_drop_b", 32'(b_gnt), 0);

    // A bursts alone, B joins when A's count is 2
    exp_a = 10'b0000001111;
    for (int k = 0; k < 5; k++) begin
      cyc(); a_req = 1; a_addr = 11'h010;
      b_req = (k >= 2); b_addr = 11'h010; #1;
      chk($sformatf("join_a%0d", k), 32'(a_gnt), 32'(exp_a[k]));
      chk($sformatf("join_b%0d", k), 32'(b_gnt), 32'(!exp_a[k]));
    end
    cyc(); idle_in(); #1;
    cyc(); #1;

    // A writes, then drops req while B reads the same word
    cyc(); a_req = 1; a_addr = 11'h020;
    a_wr_data = 32'hDEADBEEF; a_wr_en = 4'hF; #1;
    chk("wr_a_gnt", 32'(a_gnt), 1);
    chk("wr_wren", 32'(mem_wr_en), 32'hF);
    chk("wr_data", mem_wr_data, 32'hDEADBEEF);
    chk("wr_rden", 32'(mem_rd_en), 0);
    cyc(); idle_in(); b_req = 1; b_addr = 11'h020; #1;
    chk("sw_b_gnt", 32'(b_gnt), 1);
    chk("sw_a_gnt", 32'(a_gnt), 0);
    chk("wr_a_vld", 32'(a_rd_valid), 0);
    chk("sw_addr", 32'(mem_addr), 32'h020);
    cyc(); idle_in(); #1;
    chk("rdB_vld", 32'(b_rd_valid), 1);
    chk("rdB_data", b_rd_data, 32'hDEADBEEF);
    chk("rdB_avld", 32'(a_rd_valid), 0);
    cyc(); #1;
    chk("rdB_vld_end", 32'(b_rd_valid), 0);

    // A saturates its burst, reset lands after its last read
    for (int k = 0; k < 4; k++) begin
      cyc(); a_req = 1; a_addr = 11'h010; #1;
      chk($sformatf("sat_a%0d", k), 32'(a_gnt), 1);
    end
    cyc(); idle_in(); reset = 1;
    cyc(); reset = 0; a_req = 1; b_req = 1;
    a_addr = 11'h010; b_addr = 11'h020; #1;
    chk("mid_rst_vld", 32'(a_rd_valid), 0);
    chk("mid_rst_a", 32'(a_gnt), 1);
    chk("mid_rst_b", 32'(b_gnt), 0);
    cyc(); idle_in(); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares main_memory port B (data port) between two requesters: A = DisplayProcessor data memory interface, B = host/DMA loader (framebuffer/palette staging, program upload).
- Round-robin arbitration with bounded bursts, so the display processor cannot starve the loader and vice versa.
- Muxes address, write data and byte enables onto port B, and routes read data back with a per-requester valid, matching port B's 1-cycle registered read latency.

Parameters:
- MAIN_MEMORY_BYTES, 2048, memory capacity; address width AW = $clog2(MAIN_MEMORY_BYTES).
- MAX_BURST, 4, max consecutive grants to one owner while the other requester is waiting; must be >= 1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- a_req  in  1  requester A wants an access this cycle
- a_addr  in  AW  requester A byte address
- a_wr_data  in  32  requester A write data
- a_wr_en  in  4  requester A byte write enables; 0 = read
- a_gnt  out  1  A access accepted this cycle (combinational)
- a_rd_data  out  32  read data for A
- a_rd_valid  out  1  a_rd_data valid (registered)
- b_req, b_addr, b_wr_data, b_wr_en, b_gnt, b_rd_data, b_rd_valid: same as A, for requester B
- mem_addr  out  AW  to port_b_address
- mem_wr_data  out  32  to port_b_wr_data
- mem_wr_en  out  4  to port_b_wr_en
- mem_rd_en  out  1  to port_b_rd_en
- mem_rd_data  in  32  from port_b_rd_data; valid 1 cycle after the address

Behaviour:
- Clock and reset:
  - Single clock domain, clk; reset is synchronous, active-high, sampled on the rising edge, and dominates all other inputs.
- Reset values:
  - State = IDLE, burst count = 0, last_owner = B (so A wins the first tie).
  - a_rd_valid = b_rd_valid = 0.
  - While reset is high: a_gnt = b_gnt = 0, mem_wr_en = 0, mem_rd_en = 0.
- Acceptance:
  - An access is accepted on the rising edge where x_req && x_gnt.
  - A requester holds its request fields stable until it sees x_gnt.
  - x_gnt is a Mealy function of current state and both req inputs; a_gnt && b_gnt is never 1.
- Memory mux (same cycle as the grant):
  - mem_addr/mem_wr_data/mem_wr_en are taken from the granted requester.
  - mem_rd_en = 1 only for a granted access with wr_en == 0.
  - With no grant: mem_addr = 0, mem_wr_data = 0, mem_wr_en = 0, mem_rd_en = 0.
- Read return:
  - x_rd_valid is registered: 1 exactly one cycle after an accepted read by x, otherwise 0.
  - Accepted writes never raise x_rd_valid.
  - a_rd_data = b_rd_data = mem_rd_data (broadcast); consumers qualify with rd_valid.
- State IDLE:
  - Only one requester asserting: grant it.
  - Both asserting: grant the requester that is not last_owner.
  - Neither asserting: stay IDLE.
  - On a grant: next state = OWN_x, count = 1, last_owner = x.
- State OWN_x (other requester = y):
  - x_req && (count < MAX_BURST || !y_req): grant x; count increments, saturating at MAX_BURST.
  - Otherwise, if y_req: grant y in the same cycle (no bubble); next state = OWN_y, count = 1, last_owner = y.
  - Neither requesting: no grant; next state = IDLE; count = 0; last_owner unchanged.
- Boundaries:
  - MAX_BURST = 1 gives strict alternation under continuous contention.
  - A lone requester keeps the grant indefinitely; count saturates and does not wrap.
- Reset mid-operation:
  - A read accepted in the cycle before reset still returns data from memory, but rd_valid is forced to 0.
  - Any in-flight burst is abandoned.
- Throughput and latency:
  - Port B performs one access per cycle.
  - Grant latency is 0 cycles when uncontended.
  - Worst-case wait for a requester under contention is MAX_BURST cycles.

Test Plan:
- After reset, only A reads addr 0x010 on 3 consecutive cycles (memory preloaded 0x11111111) -> a_gnt = 1 all 3 cycles, mem_rd_en = 1, a_rd_valid = 1 on cycles 2-4 with a_rd_data = 0x11111111; b_gnt = 0, b_rd_valid = 0 throughout.
- A and B both hold req continuously from IDLE, MAX_BURST = 4 -> grant sequence A,A,A,A,B,B,B,B,A..., with no idle cycle at any switch.
- A bursting alone, B raises req while A's count = 2 -> A granted on its 3rd and 4th beats, B granted on the following cycle.
- A writes 0xDEADBEEF (wr_en 4'hF) to 0x020, then B reads 0x020 -> b_rd_data = 0xDEADBEEF with b_rd_valid one cycle after b_gnt; a_rd_valid stays 0 for the write.
- A in OWN_A drops req while B requests -> b_gnt = 1 in the same cycle that a_req drops.
- Reset asserted the cycle after an accepted A read -> a_rd_valid = 0 the next cycle, state = IDLE; a later simultaneous A+B request is granted to A.
